io_port_bridge: RTL and testbench

Byte-wide I/O peripheral on the far side of the processor's `In_port` / `Out_port` / `interrupt` pins. It buffers externally supplied bytes in an RX FIFO, presents the head byte on `in_port`, and signals the core by interrupt. It captures bytes the core writes with OUT into a TX FIFO and drains them to an external valid/ready sink. It sits in `top` beside the processor and replaces the bench-driven `In_port` / `interrupt` stimulus.

---
 rtl/io_port_bridge_if.sv | 44 ++++
 rtl/io_port_bridge.sv | 149 ++++++++++++++
 tb/tb_io_port_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_bridge_if
//  Brief    : Signal bundle between the processor I/O pins / external
//             byte stream and io_port_bridge. The bridge uses the slave
//             modport; the core / external side uses the master modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface io_port_bridge_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // core side
  logic [7:0]       in_port;
  logic             in_ack;
  logic [7:0]       out_port;
  logic             out_we;
  logic             interrupt;
  // external RX source
  logic [7:0]       ext_rx_data;
  logic             ext_rx_valid;
  logic             ext_rx_ready;
  // external TX sink
  logic [7:0]       ext_tx_data;
  logic             ext_tx_valid;
  logic             ext_tx_ready;
  // status
  logic [CNT_W-1:0] rx_count;
  logic             tx_drop;

  modport slave (
    output in_port, interrupt, ext_rx_ready, ext_tx_data, ext_tx_valid,
           rx_count, tx_drop,
    input  in_ack, out_port, out_we, ext_rx_data, ext_rx_valid, ext_tx_ready
  );

  modport master (
    input  in_port, interrupt, ext_rx_ready, ext_tx_data, ext_tx_valid,
           rx_count, tx_drop,
    output in_ack, out_port, out_we, ext_rx_data, ext_rx_valid, ext_tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_bridge
//  Brief    : Byte-wide I/O peripheral for the processor In_port/Out_port
//             pins. External bytes are buffered in an RX FIFO whose head is
//             presented on in_port; bytes written by OUT are queued in a TX
//             FIFO and drained to a valid/ready sink.
//  Config   : IO_BRIDGE_IRQ_EN - when defined, the interrupt pulse logic is
//             built; otherwise interrupt is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module io_port_bridge #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  io_port_bridge_if.slave  bus
);

  localparam int                 PTR_W      = $clog2(DEPTH);
  localparam int                 CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]   C_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   C_PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       r_rx_mem [DEPTH];
  logic [PTR_W-1:0] r_rx_wr_ptr;
  logic [PTR_W-1:0] r_rx_rd_ptr;
  logic [CNT_W-1:0] r_rx_count;
  logic [CNT_W-1:0] w_rx_count_next;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_rx_push;
  logic             w_rx_pop;

  assign w_rx_full  = (r_rx_count == C_FULL_CNT);
  assign w_rx_empty = (r_rx_count == '0);
  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign w_rx_push  = bus.ext_rx_valid && !w_rx_full;
  assign w_rx_pop   = bus.in_ack && !w_rx_empty;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_rx_count_next = r_rx_count;
    if (w_rx_push && !w_rx_pop) begin
      w_rx_count_next = r_rx_count + C_CNT_ONE;
    end else if (w_rx_pop && !w_rx_push) begin
      w_rx_count_next = r_rx_count - C_CNT_ONE;
    end
  end

  // RX storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr] <= bus.ext_rx_data;
    end
  end

  // RX pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + C_PTR_ONE;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + C_PTR_ONE;
      r_rx_count <= w_rx_count_next;
    end
  end

  assign bus.in_port      = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
  assign bus.ext_rx_ready = !w_rx_full;
  assign bus.rx_count     = r_rx_count;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       r_tx_mem [DEPTH];
  logic [PTR_W-1:0] r_tx_wr_ptr;
  logic [PTR_W-1:0] r_tx_rd_ptr;
  logic [CNT_W-1:0] r_tx_count;
  logic             r_tx_drop;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_tx_push;
  logic             w_tx_pop;

  assign w_tx_full  = (r_tx_count == C_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  // Fullness is judged before any same-cycle drain, so OUT on full drops.
  assign w_tx_push  = bus.out_we && !w_tx_full;
  assign w_tx_pop   = !w_tx_empty && bus.ext_tx_ready;

  // TX storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= bus.out_port;
    end
  end

  // TX pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + C_PTR_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + C_PTR_ONE;
      if (w_tx_push && !w_tx_pop) begin
        r_tx_count <= r_tx_count + C_CNT_ONE;
      end else if (w_tx_pop && !w_tx_push) begin
        r_tx_count <= r_tx_count - C_CNT_ONE;
      end
      if (bus.out_we && w_tx_full) r_tx_drop <= 1'b1;
    end
  end

  assign bus.ext_tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr];
  assign bus.ext_tx_valid = !w_tx_empty;
  assign bus.tx_drop      = r_tx_drop;

  // -------------------------------------------------------------- interrupt
`ifdef IO_BRIDGE_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  // One pulse per byte: on arrival into an empty FIFO, and on each pop that
  // leaves another byte waiting.
  assign w_irq_set = (w_rx_empty && w_rx_push) ||
                     (w_rx_pop && (w_rx_count_next != '0));

  // Single-cycle interrupt pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_set;
    end
  end

  assign bus.interrupt = r_irq;
`else
  assign bus.interrupt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_bridge
//  Brief    : Self-checking bench for io_port_bridge with a queue-based
//             reference model of both FIFOs and the interrupt rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_bridge;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  io_port_bridge_if #(.DEPTH(DEPTH)) bus ();

  io_port_bridge #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_drop;
  logic       m_irq;

  function automatic logic [7:0] exp_in_port();
    return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_tx_data();
    return (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  endfunction

  task automatic idle_inputs();
    bus.in_ack       = 1'b0;
    bus.out_port     = 8'h00;
    bus.out_we       = 1'b0;
    bus.ext_rx_data  = 8'h00;
    bus.ext_rx_valid = 1'b0;
    bus.ext_tx_ready = 1'b0;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    logic       rx_push, rx_pop, tx_push, tx_pop, irq_nxt;
    logic [7:0] rx_d, tx_d;
    int         rx_n;
    rx_n    = rx_q.size();
    rx_push = bus.ext_rx_valid && (rx_n < DEPTH);
    rx_pop  = bus.in_ack && (rx_n > 0);
    irq_nxt = ((rx_n == 0) && rx_push) ||
              (rx_pop && ((rx_n - 1 + (rx_push ? 1 : 0)) >= 1));
    tx_push = bus.out_we && (tx_q.size() < DEPTH);
    tx_pop  = bus.ext_tx_ready && (tx_q.size() > 0);
    rx_d    = bus.ext_rx_data;
    tx_d    = bus.out_port;
    if (bus.out_we && !tx_push) m_drop = 1'b1;
    @(posedge clk);
    if (rx_pop)  void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rx_d);
    if (tx_pop)  void'(tx_q.pop_front());
    if (tx_push) tx_q.push_back(tx_d);
`ifdef IO_BRIDGE_IRQ_EN
    m_irq = irq_nxt;
`else
    m_irq = 1'b0;
`endif
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_q.delete();
    tx_q.delete();
    m_drop = 1'b0;
    m_irq  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.in_port !== 8'h00) begin
      n_errors++; $display("FAIL reset_in_port: got %h expected 00", bus.in_port);
    end
    n_checks++;
    if (bus.ext_rx_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_rx_ready: got %b expected 1", bus.ext_rx_ready);
    end
    n_checks++;
    if (bus.ext_tx_valid !== 1'b0 || bus.ext_tx_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_tx: got valid %b data %h expected 0 00",
                           bus.ext_tx_valid, bus.ext_tx_data);
    end
    n_checks++;
    if (bus.interrupt !== 1'b0 || bus.tx_drop !== 1'b0) begin
      n_errors++; $display("FAIL reset_irq_drop: got %b %b expected 0 0",
                           bus.interrupt, bus.tx_drop);
    end
    n_checks++;
    if (bus.rx_count !== CNT_W'(0)) begin
      n_errors++; $display("FAIL reset_rx_count: got %0d expected 0", bus.rx_count);
    end
  endtask

  task automatic test_rx_single();
    logic exp_irq;
`ifdef IO_BRIDGE_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    do_reset();
    bus.ext_rx_data = 8'hA5; bus.ext_rx_valid = 1'b1;
    tick();
    bus.ext_rx_valid = 1'b0;
    n_checks++;
    if (bus.in_port !== 8'hA5 || bus.rx_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL rx_single: got in_port %h count %0d expected A5 1",
                           bus.in_port, bus.rx_count);
    end
    n_checks++;
    if (bus.interrupt !== exp_irq) begin
      n_errors++; $display("FAIL rx_single_irq: got %b expected %b", bus.interrupt, exp_irq);
    end
    tick();
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_errors++; $display("FAIL rx_single_irq_width: got %b expected 0", bus.interrupt);
    end
  endtask

  task automatic test_rx_full();
    logic [7:0] seq  [4];
    logic [7:0] head [4];
    logic       rdy  [4];
    logic       irq  [4];
    seq  = '{8'h11, 8'h22, 8'h33, 8'h44};
    head = '{8'h22, 8'h33, 8'h44, 8'h00};
    rdy  = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef IO_BRIDGE_IRQ_EN
    irq  = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    irq  = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.ext_rx_data = seq[i]; bus.ext_rx_valid = 1'b1;
      tick();
      n_checks++;
      if (bus.ext_rx_ready !== rdy[i]) begin
        n_errors++; $display("FAIL rx_fill_ready[%0d]: got %b expected %b",
                             i, bus.ext_rx_ready, rdy[i]);
      end
    end
    bus.ext_rx_data = 8'h55;
    tick();
    bus.ext_rx_valid = 1'b0;
    n_checks++;
    if (bus.rx_count !== CNT_W'(4) || bus.in_port !== 8'h11) begin
      n_errors++; $display("FAIL rx_overflow: got count %0d head %h expected 4 11",
                           bus.rx_count, bus.in_port);
    end
    bus.in_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.in_port !== head[i] || bus.interrupt !== irq[i]) begin
        n_errors++; $display("FAIL rx_pop[%0d]: got head %h irq %b expected %h %b",
                             i, bus.in_port, bus.interrupt, head[i], irq[i]);
      end
    end
    bus.in_ack = 1'b0;
  endtask

  task automatic test_rx_empty_ack();
    do_reset();
    bus.in_ack = 1'b1;
    tick();
    bus.in_ack = 1'b0;
    n_checks++;
    if (bus.rx_count !== CNT_W'(0) || bus.interrupt !== 1'b0) begin
      n_errors++; $display("FAIL rx_empty_ack: got count %0d irq %b expected 0 0",
                           bus.rx_count, bus.interrupt);
    end
    bus.ext_rx_data = 8'h7E; bus.ext_rx_valid = 1'b1;
    tick();
    bus.ext_rx_valid = 1'b0;
    n_checks++;
    if (bus.in_port !== 8'h7E || bus.rx_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL rx_after_empty_ack: got %h count %0d expected 7E 1",
                           bus.in_port, bus.rx_count);
    end
  endtask

  task automatic test_tx_drop();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.out_port = 8'(i); bus.out_we = 1'b1;
      tick();
      n_checks++;
      if (bus.tx_drop !== (i == 5)) begin
        n_errors++; $display("FAIL tx_drop_after_%0d: got %b expected %b",
                             i, bus.tx_drop, (i == 5));
      end
    end
    bus.out_we = 1'b0;
    bus.ext_tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (bus.ext_tx_valid !== 1'b1 || bus.ext_tx_data !== 8'(k)) begin
        n_errors++; $display("FAIL tx_drain_%0d: got valid %b data %h expected 1 %h",
                             k, bus.ext_tx_valid, bus.ext_tx_data, 8'(k));
      end
      tick();
    end
    bus.ext_tx_ready = 1'b0;
    n_checks++;
    if (bus.ext_tx_valid !== 1'b0 || bus.tx_drop !== 1'b1) begin
      n_errors++; $display("FAIL tx_drained: got valid %b drop %b expected 0 1",
                           bus.ext_tx_valid, bus.tx_drop);
    end
  endtask

  task automatic test_tx_drop_while_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.out_port = 8'hB0 + 8'(i); bus.out_we = 1'b1;
      tick();
    end
    bus.out_port = 8'hEE; bus.ext_tx_ready = 1'b1;
    tick();
    bus.out_we = 1'b0;
    n_checks++;
    if (bus.tx_drop !== 1'b1 || bus.ext_tx_data !== 8'hB1) begin
      n_errors++; $display("FAIL tx_full_drain_drop: got drop %b head %h expected 1 B1",
                           bus.tx_drop, bus.ext_tx_data);
    end
    for (int k = 2; k < DEPTH; k++) tick();
    tick();
    bus.ext_tx_ready = 1'b0;
    n_checks++;
    if (bus.ext_tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL tx_full_drain_empty: got valid %b expected 0",
                           bus.ext_tx_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.out_port = 8'h60 + 8'(i); bus.out_we = 1'b1;
      tick();
    end
    bus.out_we = 1'b0;
    bus.ext_tx_ready = 1'b1;
    tick();
    tick();
    // two bytes pending, drain handshake still active
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ext_tx_valid !== 1'b0 || bus.tx_drop !== 1'b0 || bus.interrupt !== 1'b0) begin
      n_errors++; $display("FAIL async_reset: got valid %b drop %b irq %b expected 0 0 0",
                           bus.ext_tx_valid, bus.tx_drop, bus.interrupt);
    end
    idle_inputs();
    rx_q.delete(); tx_q.delete(); m_drop = 1'b0; m_irq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_port = 8'h9C; bus.out_we = 1'b1;
    tick();
    bus.out_we = 1'b0; bus.ext_tx_ready = 1'b1;
    n_checks++;
    if (bus.ext_tx_valid !== 1'b1 || bus.ext_tx_data !== 8'h9C) begin
      n_errors++; $display("FAIL post_reset_push: got valid %b data %h expected 1 9C",
                           bus.ext_tx_valid, bus.ext_tx_data);
    end
    tick();
    bus.ext_tx_ready = 1'b0;
    n_checks++;
    if (bus.ext_tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_only_one: got valid %b expected 0",
                           bus.ext_tx_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.ext_rx_data  = 8'($urandom);
      bus.ext_rx_valid = ($urandom_range(0, 99) < 45);
      bus.in_ack       = ($urandom_range(0, 99) < 40);
      bus.out_port     = 8'($urandom);
      bus.out_we       = ($urandom_range(0, 99) < 40);
      bus.ext_tx_ready = ($urandom_range(0, 99) < 45);
      tick();
      n_checks++;
      if (bus.in_port !== exp_in_port() || bus.rx_count !== CNT_W'(rx_q.size()) ||
          bus.ext_rx_ready !== (rx_q.size() < DEPTH)) begin
        n_errors++; $display("FAIL rand_rx[%0d]: got head %h count %0d ready %b expected %h %0d %b",
                             c, bus.in_port, bus.rx_count, bus.ext_rx_ready,
                             exp_in_port(), rx_q.size(), (rx_q.size() < DEPTH));
      end
      n_checks++;
      if (bus.ext_tx_valid !== (tx_q.size() != 0) || bus.ext_tx_data !== exp_tx_data() ||
          bus.tx_drop !== m_drop) begin
        n_errors++; $display("FAIL rand_tx[%0d]: got valid %b data %h drop %b expected %b %h %b",
                             c, bus.ext_tx_valid, bus.ext_tx_data, bus.tx_drop,
                             (tx_q.size() != 0), exp_tx_data(), m_drop);
      end
      n_checks++;
      if (bus.interrupt !== m_irq) begin
        n_errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", c, bus.interrupt, m_irq);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_drop = 1'b0;
    m_irq  = 1'b0;
    test_reset();
    test_rx_single();
    test_rx_full();
    test_rx_empty_ack();
    test_tx_drop();
    test_tx_drop_while_drain();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
